xalu_issue_ctrl: RTL and testbench

- Issue/sequencing controller for the multiply/divide unit (HI/LO datapath) in the 5-stage MIPS pipeline.
- Decodes the E-stage MDU op, generates the unit's start pulse and stalls E while a long op is in flight.
- Requests HI/LO rollback when the issuing instruction excepts in M, and cross-checks its latency model against the unit's busy flag.

---
 rtl/xalu_pkg.sv | 46 ++++
 rtl/xalu_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_xalu_issue_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xalu_pkg.sv
// xalu_pkg: op codes, class decode and controller state for the
// multiply/divide (HI/LO) unit and its issue controller.
package xalu_pkg;

   localparam int MUL_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF = 10;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_MTHI  = 4'd3;
   localparam logic [3:0] OP_MTLO  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_DIV   = 4'd7;
   localparam logic [3:0] OP_DIVU  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } xalu_state_t;

   function automatic logic is_write(input logic [3:0] op);
      return op inside {OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO,
                        OP_DIV, OP_DIVU, OP_MADD, OP_MADDU};
   endfunction

   function automatic logic is_read(input logic [3:0] op);
      return op inside {OP_MFHI, OP_MFLO};
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return op inside {OP_DIV, OP_DIVU};
   endfunction

   // Divide by zero leaves HI/LO untouched, so it is not long.
   function automatic logic is_long(input logic [3:0] op,
                                    input logic       d2_zero);
      return (op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU})
           | (is_div(op) & !d2_zero);
   endfunction

endpackage

// File: rtl/xalu_issue_ctrl.sv
// xalu_issue_ctrl: issues HI/LO ops, stalls E during long ops,
// requests rollback on M exceptions. Option: XALU_ISSUE_CTRL_STATS_EN.
module xalu_issue_ctrl
   import xalu_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       e_valid,
   input  logic [3:0] e_op,
   input  logic       e_d2_zero,
   input  logic       e_flush,
   input  logic       m_exc,
   input  logic       xalu_busy,
   output logic       xalu_start,
   output logic [3:0] xalu_op,
   output logic       xalu_rollback,
   output logic       stall_e,
   output logic       ctrl_busy,
   output logic       mismatch
`ifdef XALU_ISSUE_CTRL_STATS_EN
   ,
   output logic [31:0] stat_issue,
   output logic [31:0] stat_stall
`endif
);

   localparam logic [CNT_W-1:0] MUL_LD  = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   xalu_state_t      state;
   xalu_state_t      state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             pend_m;
   logic             post_long;
   logic             op_write;
   logic             op_mdu;
   logic             op_long;
   logic             idle;
   logic             chk_err;

   assign op_write = is_write(e_op);
   assign op_mdu   = op_write | is_read(e_op);
   assign op_long  = is_long(e_op, e_d2_zero);
   assign idle     = (state == IDLE);

   assign xalu_op       = e_op;
   assign ctrl_busy     = !idle;
   assign stall_e       = !reset & e_valid & op_mdu & (!idle | xalu_busy);
   assign xalu_rollback = !reset & pend_m & m_exc;
   assign xalu_start    = !reset & e_valid & op_write & !e_flush
                        & !stall_e & !xalu_rollback;

   // Busy rises at the edge after a long issue, so skip that cycle.
   assign chk_err = ((state == RUN) & !xalu_busy & !post_long)
                  | (idle & xalu_busy & !xalu_rollback);

   // Next state and countdown; rollback of an in-flight op wins.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (xalu_rollback & ((state == RUN) | xalu_busy)) begin
         state_nxt = DRAIN;
         cnt_nxt   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (xalu_start & op_long) begin
                  state_nxt = RUN;
                  cnt_nxt   = is_div(e_op) ? DIV_LD : MUL_LD;
               end
            end
            RUN: begin
               cnt_nxt = cnt - CNT_ONE;
               if (cnt == CNT_ONE) state_nxt = IDLE;
            end
            DRAIN: begin
               if (!xalu_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State, issue history and sticky model/unit disagreement flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         pend_m    <= 1'b0;
         post_long <= 1'b0;
         mismatch  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pend_m    <= xalu_start;
         post_long <= xalu_start & op_long;
         if (chk_err) mismatch <= 1'b1;
      end
   end

`ifdef XALU_ISSUE_CTRL_STATS_EN
   if (1) begin : g_stats
      // Free-running issue and stall counters, wrapping at 2^32.
      always_ff @(posedge clk) begin
         if (reset) begin
            stat_issue <= '0;
            stat_stall <= '0;
         end else begin
            if (xalu_start) stat_issue <= stat_issue + 32'd1;
            if (stall_e)    stat_stall <= stat_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_xalu_issue_ctrl.sv
// tb_xalu_issue_ctrl: directed and random checks of the HI/LO issue
// controller against a cycle-count reference model and a unit stub.
module tb_xalu_issue_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       e_valid = 1'b0;
   logic [3:0] e_op = 4'd0;
   logic       e_d2_zero = 1'b0;
   logic       e_flush = 1'b0;
   logic       m_exc = 1'b0;
   logic       xalu_busy = 1'b0;
   logic       xalu_start;
   logic [3:0] xalu_op;
   logic       xalu_rollback;
   logic       stall_e;
   logic       ctrl_busy;
   logic       mismatch;
`ifdef XALU_ISSUE_CTRL_STATS_EN
   logic [31:0] stat_issue;
   logic [31:0] stat_stall;
`endif

   always #5 clk = ~clk;

   xalu_issue_ctrl dut (
      .clk(clk),
      .reset(reset),
      .e_valid(e_valid),
      .e_op(e_op),
      .e_d2_zero(e_d2_zero),
      .e_flush(e_flush),
      .m_exc(m_exc),
      .xalu_busy(xalu_busy),
      .xalu_start(xalu_start),
      .xalu_op(xalu_op),
      .xalu_rollback(xalu_rollback),
      .stall_e(stall_e),
      .ctrl_busy(ctrl_busy),
      .mismatch(mismatch)
`ifdef XALU_ISSUE_CTRL_STATS_EN
      ,
      .stat_issue(stat_issue),
      .stat_stall(stat_stall)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   int mul_lat = 5;
   int div_lat = 10;
   int unit_left = 0;

   int run_left = 0;
   bit drain = 0;
   bit pend = 0;
   bit after_long = 0;
   bit mm = 0;
   int cnt_issue = 0;
   int cnt_stall = 0;

   bit x_start, x_stall, x_rb, x_cbusy, x_mm, x_err;

   function automatic bit m_write(input int op);
      return op inside {1, 2, 3, 4, 7, 8, 9, 10};
   endfunction

   function automatic bit m_mdu(input int op);
      return op >= 1 && op <= 10;
   endfunction

   function automatic bit m_long(input int op, input bit z);
      return (op inside {1, 2, 9, 10}) || ((op inside {7, 8}) && !z);
   endfunction

   task automatic apply(input bit v, input int op, input bit z,
                        input bit fl, input bit ex);
      e_valid = v;
      e_op = 4'(op);
      e_d2_zero = z;
      e_flush = fl;
      m_exc = ex;
      xalu_busy = (unit_left > 0);
      #1;
      x_cbusy = (run_left > 0) || drain;
      x_rb = !reset && pend && ex;
      x_stall = !reset && v && m_mdu(op) && (x_cbusy || xalu_busy);
      x_start = !reset && v && m_write(op) && !fl && !x_stall && !x_rb;
      x_mm = mm;
      x_err = ((run_left > 0) && !xalu_busy && !after_long)
           || (!x_cbusy && xalu_busy && !x_rb);
   endtask

   task automatic adv();
      int op;
      bit lng;
      bit div;
      op = int'(e_op);
      lng = m_long(op, e_d2_zero);
      div = (op == 7) || (op == 8);
      @(posedge clk);
      if (reset) begin
         run_left = 0; drain = 0; pend = 0; after_long = 0; mm = 0;
         unit_left = 0; cnt_issue = 0; cnt_stall = 0;
      end else begin
         if (x_start) cnt_issue++;
         if (x_stall) cnt_stall++;
         if (x_err) mm = 1;
         if (x_rb && ((run_left > 0) || xalu_busy)) begin
            drain = 1;
            run_left = 0;
         end else if (run_left > 0) begin
            run_left--;
         end else if (drain) begin
            if (!xalu_busy) drain = 0;
         end else if (x_start && lng) begin
            run_left = div ? 10 : 5;
         end
         if (x_rb && unit_left > 0) unit_left = int'($urandom_range(0, 3));
         else if (unit_left > 0) unit_left--;
         if (x_start && lng) unit_left = div ? div_lat : mul_lat;
         pend = x_start;
         after_long = x_start && lng;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      apply(1, 1, 0, 0, 1);
      adv();
      apply(0, 0, 0, 0, 0);
      adv();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      apply(1, 1, 0, 0, 1);
      adv();
      apply(1, 1, 0, 0, 1);
      n_cmp++;
      if ({xalu_start, stall_e, xalu_rollback} !== 3'b000) begin
         n_err++;
         $display("FAIL rst_force: got %b want 000",
                  {xalu_start, stall_e, xalu_rollback});
      end
      n_cmp++;
      if ({ctrl_busy, mismatch} !== 2'b00) begin
         n_err++;
         $display("FAIL rst_state: got %b want 00", {ctrl_busy, mismatch});
      end
      n_cmp++;
      if (xalu_op !== 4'd1) begin
         n_err++;
         $display("FAIL rst_op_pass: got %0d want 1", xalu_op);
      end
      adv();
      reset = 1'b0;
      apply(1, 1, 0, 0, 0);
      n_cmp++;
      if (xalu_start !== 1'b1) begin
         n_err++;
         $display("FAIL rst_pre_start: got %b want 1", xalu_start);
      end
      adv();
      reset = 1'b1;
      apply(1, 6, 0, 0, 1);
      n_cmp++;
      if ({xalu_start, stall_e, xalu_rollback} !== 3'b000) begin
         n_err++;
         $display("FAIL rst_mid_force: got %b want 000",
                  {xalu_start, stall_e, xalu_rollback});
      end
      adv();
      reset = 1'b0;
      apply(1, 6, 0, 0, 0);
      n_cmp++;
      if ({ctrl_busy, stall_e} !== 2'b00) begin
         n_err++;
         $display("FAIL rst_mid_abort: got %b want 00", {ctrl_busy, stall_e});
      end
      adv();
   endtask

   task automatic test_mult();
      do_reset();
      apply(1, 1, 0, 0, 0);
      n_cmp++;
      if (xalu_start !== 1'b1) begin
         n_err++;
         $display("FAIL mult_start: got %b want 1", xalu_start);
      end
      adv();
      for (int k = 1; k <= 6; k++) begin
         apply(1, 6, 0, 0, 0);
         n_cmp++;
         if ({stall_e, ctrl_busy} !== {2{k <= 5}}) begin
            n_err++;
            $display("FAIL mult_stall c%0d: got %b want %b", k,
                     {stall_e, ctrl_busy}, {2{k <= 5}});
         end
         adv();
      end
      apply(0, 0, 0, 0, 0);
      n_cmp++;
      if (mismatch !== 1'b0) begin
         n_err++;
         $display("FAIL mult_mismatch: got %b want 0", mismatch);
      end
      adv();
   endtask

   task automatic test_div();
      do_reset();
      apply(1, 7, 0, 0, 0);
      n_cmp++;
      if (xalu_start !== 1'b1) begin
         n_err++;
         $display("FAIL div_start: got %b want 1", xalu_start);
      end
      adv();
      for (int k = 1; k <= 11; k++) begin
         apply(1, 5, 0, 0, 0);
         n_cmp++;
         if (stall_e !== (k <= 10)) begin
            n_err++;
            $display("FAIL div_stall c%0d: got %b want %b", k, stall_e, k <= 10);
         end
         adv();
      end
      apply(1, 7, 1, 0, 0);
      n_cmp++;
      if (xalu_start !== 1'b1) begin
         n_err++;
         $display("FAIL div0_start: got %b want 1", xalu_start);
      end
      adv();
      apply(1, 5, 0, 0, 0);
      n_cmp++;
      if ({stall_e, ctrl_busy, mismatch} !== 3'b000) begin
         n_err++;
         $display("FAIL div0_nostall: got %b want 000",
                  {stall_e, ctrl_busy, mismatch});
      end
      adv();
   endtask

   task automatic test_rollback();
      bit done;
      do_reset();
      apply(1, 1, 0, 0, 0);
      adv();
      apply(1, 3, 0, 0, 1);
      n_cmp++;
      if ({xalu_rollback, xalu_start} !== 2'b10) begin
         n_err++;
         $display("FAIL rb_long: got %b want 10", {xalu_rollback, xalu_start});
      end
      adv();
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         apply(0, 0, 0, 0, 0);
         n_cmp++;
         if (ctrl_busy !== 1'b1) begin
            n_err++;
            $display("FAIL rb_drain c%0d: got %b want 1", k, ctrl_busy);
         end
         done = !xalu_busy;
         adv();
      end
      apply(0, 0, 0, 0, 0);
      n_cmp++;
      if (!done || ctrl_busy !== 1'b0 || mismatch !== 1'b0) begin
         n_err++;
         $display("FAIL rb_idle: got done=%b busy=%b mm=%b want 1 0 0",
                  done, ctrl_busy, mismatch);
      end
      adv();
      apply(1, 3, 0, 0, 0);
      adv();
      apply(1, 4, 0, 0, 1);
      n_cmp++;
      if ({xalu_rollback, xalu_start, stall_e} !== 3'b100) begin
         n_err++;
         $display("FAIL rb_suppress: got %b want 100",
                  {xalu_rollback, xalu_start, stall_e});
      end
      adv();
   endtask

   task automatic test_back_to_back();
      do_reset();
      apply(1, 3, 0, 0, 0);
      n_cmp++;
      if ({xalu_start, stall_e} !== 2'b10) begin
         n_err++;
         $display("FAIL b2b_mthi: got %b want 10", {xalu_start, stall_e});
      end
      adv();
      apply(1, 4, 0, 0, 0);
      n_cmp++;
      if ({xalu_start, stall_e} !== 2'b10) begin
         n_err++;
         $display("FAIL b2b_mtlo: got %b want 10", {xalu_start, stall_e});
      end
      adv();
      apply(1, 6, 0, 0, 0);
      n_cmp++;
      if ({xalu_start, stall_e, ctrl_busy} !== 3'b000) begin
         n_err++;
         $display("FAIL b2b_mflo: got %b want 000",
                  {xalu_start, stall_e, ctrl_busy});
      end
      adv();
   endtask

   task automatic test_flush();
      do_reset();
      apply(1, 1, 0, 1, 0);
      n_cmp++;
      if ({xalu_start, stall_e} !== 2'b00) begin
         n_err++;
         $display("FAIL flush_start: got %b want 00", {xalu_start, stall_e});
      end
      adv();
      apply(1, 6, 0, 0, 0);
      n_cmp++;
      if ({stall_e, ctrl_busy} !== 2'b00) begin
         n_err++;
         $display("FAIL flush_nostall: got %b want 00", {stall_e, ctrl_busy});
      end
      adv();
   endtask

   task automatic test_mismatch();
      do_reset();
      mul_lat = 4;
      apply(1, 1, 0, 0, 0);
      adv();
      for (int k = 1; k <= 10; k++) begin
         apply(0, 0, 0, 0, 0);
         n_cmp++;
         if (mismatch !== x_mm) begin
            n_err++;
            $display("FAIL mm_track c%0d: got %b want %b", k, mismatch, x_mm);
         end
         adv();
      end
      apply(0, 0, 0, 0, 0);
      n_cmp++;
      if (mismatch !== 1'b1) begin
         n_err++;
         $display("FAIL mm_sticky: got %b want 1", mismatch);
      end
      mul_lat = 5;
      do_reset();
      apply(0, 0, 0, 0, 0);
      n_cmp++;
      if (mismatch !== 1'b0) begin
         n_err++;
         $display("FAIL mm_clear: got %b want 0", mismatch);
      end
      adv();
   endtask

   task automatic test_random();
      bit v, z, fl, ex;
      int op;
      do_reset();
      for (int k = 0; k < 800; k++) begin
         if (k == 400) do_reset();
         v = $urandom_range(0, 3) != 0;
         op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                          : int'($urandom_range(1, 10));
         z = $urandom_range(0, 3) == 0;
         fl = $urandom_range(0, 7) == 0;
         ex = $urandom_range(0, 4) == 0;
         apply(v, op, z, fl, ex);
         n_cmp++;
         if ({xalu_start, stall_e, xalu_rollback} !== {x_start, x_stall, x_rb}) begin
            n_err++;
            $display("FAIL rnd_ctl c%0d: got %b want %b", k,
                     {xalu_start, stall_e, xalu_rollback},
                     {x_start, x_stall, x_rb});
         end
         n_cmp++;
         if ({ctrl_busy, mismatch} !== {x_cbusy, x_mm}) begin
            n_err++;
            $display("FAIL rnd_state c%0d: got %b want %b", k,
                     {ctrl_busy, mismatch}, {x_cbusy, x_mm});
         end
         n_cmp++;
         if (xalu_op !== 4'(op)) begin
            n_err++;
            $display("FAIL rnd_op c%0d: got %0d want %0d", k, xalu_op, op);
         end
         adv();
      end
      apply(0, 0, 0, 0, 0);
`ifdef XALU_ISSUE_CTRL_STATS_EN
      n_cmp++;
      if (stat_issue !== 32'(cnt_issue)) begin
         n_err++;
         $display("FAIL stat_issue: got %0d want %0d", stat_issue, cnt_issue);
      end
      n_cmp++;
      if (stat_stall !== 32'(cnt_stall)) begin
         n_err++;
         $display("FAIL stat_stall: got %0d want %0d", stat_stall, cnt_stall);
      end
`endif
      adv();
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_rollback();
      test_back_to_back();
      test_flush();
      test_mismatch();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
